// File: rtl/jtag_debug_cmd_sysclk_bridge.sv
// jtag_debug_cmd_sysclk_bridge
//   System-clock side of the CPU JTAG debug link. The virtual-JTAG update
//   strobes (vs_uir, vs_udr) arrive from the tck domain. They are
//   synchronised into clk and edge-detected. On an accepted update-DR, the
//   shift register is captured into jdo and a one-hot pulse is issued on
//   take_action or take_no_action. The pulse is indexed by the latched IR,
//   and sr[ACT_BIT] picks which of the two vectors fires.
//   With HANDSHAKE=1 a command stays pending until cmd_ack. Any update-DR
//   that arrives while a command is pending is dropped and counted in a
//   saturating overrun counter.
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   ir_in          virtual IR (tck domain, quasi-static)
//   sr             JTAG shift register (tck domain, stable after vs_udr)
//   vs_uir/vs_udr  update-IR / update-DR strobes (tck domain)
//   cmd_ack        consumer done; only meaningful when HANDSHAKE=1
//   jdo            captured DR contents, held between commands
//   cmd_ir         IR of the last accepted command
//   take_action    one-hot single-cycle pulse, sr[ACT_BIT]=1
//   take_no_action one-hot single-cycle pulse, sr[ACT_BIT]=0
//   cmd_pending    command accepted and not yet acknowledged
//   overrun_cnt    saturating count of dropped commands
module jtag_debug_cmd_sysclk_bridge #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int HANDSHAKE   = 0,
  parameter int OVR_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IR_WIDTH-1:0]      ir_in,
  input  logic [DR_WIDTH-1:0]      sr,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic                     cmd_ack,
  output logic [DR_WIDTH-1:0]      jdo,
  output logic [IR_WIDTH-1:0]      cmd_ir,
  output logic [(1<<IR_WIDTH)-1:0] take_action,
  output logic [(1<<IR_WIDTH)-1:0] take_no_action,
  output logic                     cmd_pending,
  output logic [OVR_WIDTH-1:0]     overrun_cnt
);

  localparam int NCMD = 1 << IR_WIDTH;

  typedef enum logic [0:0] {IDLE, WAIT_ACK} state_t;

  state_t                  state_reg;
  logic [SYNC_STAGES-1:0]  prime_reg;
  logic                    primed;
  logic [1:0]              strobe_in;
  logic [1:0]              strobe_rise;   // [0] = update-IR, [1] = update-DR
  logic                    uir_rise;
  logic                    udr_rise;
  logic [IR_WIDTH-1:0]     ir_latched_reg;
  logic [IR_WIDTH-1:0]     ir_eff;
  logic [NCMD-1:0]         cmd_onehot;

  assign strobe_in = {vs_udr, vs_uir};
  assign uir_rise  = strobe_rise[0];
  assign udr_rise  = strobe_rise[1];

  // prime_reg fills with ones at the same pace as the synchroniser chains.
  // Its last stage is therefore high only once the chain outputs carry real
  // post-reset samples. Without it, the zeros left by reset would count as
  // "seen low" and a strobe held high across reset release would look like
  // a fresh rise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prime_reg <= '0;
    end else begin
      prime_reg <= {prime_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end
  assign primed = prime_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_strobe
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   dly_reg;
      logic                   arm_reg;
      logic                   sync_out;

      assign sync_out = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync_reg <= '0;
          dly_reg  <= 1'b0;
          arm_reg  <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], strobe_in[gi]};
          dly_reg  <= sync_out;
          if (primed && !sync_out) begin
            arm_reg <= 1'b1;
          end
        end
      end

      assign strobe_rise[gi] = sync_out & ~dly_reg & arm_reg;
    end
  endgenerate

  // ir_in is quasi-static, so it is sampled directly on the update-IR rise.
  // When update-IR and update-DR rise together, the command uses the new IR.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_latched_reg <= '0;
    end else if (uir_rise) begin
      ir_latched_reg <= ir_in;
    end
  end

  assign ir_eff = uir_rise ? ir_in : ir_latched_reg;

  generate
    for (gi = 0; gi < NCMD; gi++) begin : g_decode
      assign cmd_onehot[gi] = (ir_eff == IR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      jdo            <= '0;
      cmd_ir         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      cmd_pending    <= 1'b0;
      overrun_cnt    <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      case (state_reg)
        IDLE: begin
          if (udr_rise) begin
            jdo    <= sr;
            cmd_ir <= ir_eff;
            if (sr[ACT_BIT]) begin
              take_action <= cmd_onehot;
            end else begin
              take_no_action <= cmd_onehot;
            end
            if (HANDSHAKE != 0) begin
              state_reg   <= WAIT_ACK;
              cmd_pending <= 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          if (cmd_ack) begin
            state_reg   <= IDLE;
            cmd_pending <= 1'b0;
          end
          // A new command is dropped even when the ack lands on the same edge.
          if (udr_rise && (overrun_cnt != '1)) begin
            overrun_cnt <= overrun_cnt + OVR_WIDTH'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk_bridge.sv
// Bench for jtag_debug_cmd_sysclk_bridge. It drives three instances from one
// shared stimulus:
//   A: default parameters
//   B: HANDSHAKE=1, OVR_WIDTH=2
//   C: IR_WIDTH=3, SYNC_STAGES=3
// Each instance is followed by an event-level model. The model keeps the
// sampled strobe and reset histories, and judges a command from the raw
// samples SYNC_STAGES edges back. Directed checks with literal values pin the
// model.
module tb_jtag_debug_cmd_sysclk_bridge;

  logic        clk = 1'b0;
  logic        reset_n, vs_uir, vs_udr, cmd_ack;
  logic [2:0]  ir_in;
  logic [37:0] sr;

  logic [37:0] jdo_a, jdo_b, jdo_c;
  logic [1:0]  cmd_ir_a, cmd_ir_b;
  logic [2:0]  cmd_ir_c;
  logic [3:0]  ta_a, tna_a, ta_b, tna_b;
  logic [7:0]  ta_c, tna_c;
  logic        pend_a, pend_b, pend_c;
  logic [7:0]  ovr_a, ovr_c;
  logic [1:0]  ovr_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit started = 0;

  always #5 clk = ~clk;

  jtag_debug_cmd_sysclk_bridge dut_a (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in[1:0]), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ack(cmd_ack),
    .jdo(jdo_a), .cmd_ir(cmd_ir_a), .take_action(ta_a), .take_no_action(tna_a),
    .cmd_pending(pend_a), .overrun_cnt(ovr_a));

  jtag_debug_cmd_sysclk_bridge #(.HANDSHAKE(1), .OVR_WIDTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in[1:0]), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ack(cmd_ack),
    .jdo(jdo_b), .cmd_ir(cmd_ir_b), .take_action(ta_b), .take_no_action(tna_b),
    .cmd_pending(pend_b), .overrun_cnt(ovr_b));

  jtag_debug_cmd_sysclk_bridge #(.IR_WIDTH(3), .SYNC_STAGES(3)) dut_c (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ack(cmd_ack),
    .jdo(jdo_c), .cmd_ir(cmd_ir_c), .take_action(ta_c), .take_no_action(tna_c),
    .cmd_pending(pend_c), .overrun_cnt(ovr_c));

  // ---------------- model ----------------
  typedef struct {
    logic [37:0] jdo;
    logic [2:0]  cmd_ir;
    logic [7:0]  ta;
    logic [7:0]  tna;
    logic        pend;
    int          ovr;
    logic [2:0]  ir_lat;
  } mstate_t;

  mstate_t ma, mb, mc;
  bit udr_h [0:16383];
  bit uir_h [0:16383];
  bit rst_h [0:16383];

  // A raw strobe rise sampled at edge t counts at edge n only if reset was
  // released at every edge from t-1 through n.
  function automatic bit rise(int which, int t, int n);
    if (t < 1) return 1'b0;
    for (int k = t - 1; k <= n; k++) begin
      if (!rst_h[k]) return 1'b0;
    end
    if (which == 0) return udr_h[t] && !udr_h[t-1];
    return uir_h[t] && !uir_h[t-1];
  endfunction

  function automatic mstate_t step(mstate_t m, int s, bit hs, int omax,
                                   logic [2:0] msk, int n);
    mstate_t    r;
    bit         u_ev, d_ev;
    logic [2:0] ir_eff;
    r = m;
    r.ta = 8'h0;
    r.tna = 8'h0;
    if (!rst_h[n]) begin
      r.jdo = '0; r.cmd_ir = '0; r.pend = 1'b0; r.ovr = 0; r.ir_lat = '0;
      return r;
    end
    u_ev = rise(1, n - s, n);
    d_ev = rise(0, n - s, n);
    ir_eff = (u_ev ? ir_in : m.ir_lat) & msk;
    if (u_ev) r.ir_lat = ir_in & msk;
    if (!m.pend) begin
      if (d_ev) begin
        r.jdo = sr;
        r.cmd_ir = ir_eff;
        if (sr[35]) r.ta = 8'd1 << ir_eff;
        else        r.tna = 8'd1 << ir_eff;
        if (hs) r.pend = 1'b1;
      end
    end else begin
      if (cmd_ack) r.pend = 1'b0;
      if (d_ev && m.ovr < omax) r.ovr = m.ovr + 1;
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      udr_h[cyc] = vs_udr;
      uir_h[cyc] = vs_uir;
      rst_h[cyc] = reset_n;
      ma = step(ma, 2, 1'b0, 255, 3'b011, cyc);
      mb = step(mb, 2, 1'b1, 3,   3'b011, cyc);
      mc = step(mc, 3, 1'b0, 255, 3'b111, cyc);
      cyc++;
      started = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every instance against its model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("A.jdo", 64'(jdo_a), 64'(ma.jdo));
        chk("A.cmd_ir", 64'(cmd_ir_a), 64'(ma.cmd_ir));
        chk("A.take_action", 64'(ta_a), 64'(ma.ta));
        chk("A.take_no_action", 64'(tna_a), 64'(ma.tna));
        chk("A.cmd_pending", 64'(pend_a), 64'(ma.pend));
        chk("A.overrun_cnt", 64'(ovr_a), 64'(ma.ovr));
        chk("B.jdo", 64'(jdo_b), 64'(mb.jdo));
        chk("B.cmd_ir", 64'(cmd_ir_b), 64'(mb.cmd_ir));
        chk("B.take_action", 64'(ta_b), 64'(mb.ta));
        chk("B.take_no_action", 64'(tna_b), 64'(mb.tna));
        chk("B.cmd_pending", 64'(pend_b), 64'(mb.pend));
        chk("B.overrun_cnt", 64'(ovr_b), 64'(mb.ovr));
        chk("C.jdo", 64'(jdo_c), 64'(mc.jdo));
        chk("C.cmd_ir", 64'(cmd_ir_c), 64'(mc.cmd_ir));
        chk("C.take_action", 64'(ta_c), 64'(mc.ta));
        chk("C.take_no_action", 64'(tna_c), 64'(mc.tna));
        chk("C.cmd_pending", 64'(pend_c), 64'(mc.pend));
        chk("C.overrun_cnt", 64'(ovr_c), 64'(mc.ovr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus (all tasks start and end on a negedge) --------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_uir(input logic [2:0] v);
    ir_in = v;
    vs_uir = 1'b1;
    wait_n(4);
    vs_uir = 1'b0;
    wait_n(4);
  endtask

  // Issues one update-DR. pa/pb count the cycles with any pulse on A/B.
  task automatic send_cmd(input logic [37:0] v, output int pa, output int pb);
    pa = 0;
    pb = 0;
    sr = v;
    vs_udr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) vs_udr = 1'b0;
      @(negedge clk);
      if ((ta_a | tna_a) != 4'h0) pa++;
      if ((ta_b | tna_b) != 4'h0) pb++;
    end
  endtask

  int pa, pb, pc;

  initial begin
    reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b1; cmd_ack = 1'b0;
    ir_in = 3'd0; sr = '0;
    wait_n(5);
    reset_n = 1'b1;

    // 1. strobe held high across reset release is ignored
    pa = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((ta_a | tna_a) != 4'h0) pa++;
    end
    chk("t1.no_pulse", 64'(pa), 64'd0);
    chk("t1.jdo", 64'(jdo_a), 64'd0);
    chk("t1.overrun", 64'(ovr_a), 64'd0);
    vs_udr = 1'b0;
    wait_n(4);
    send_cmd(38'h1, pa, pb);
    chk("t1.one_pulse", 64'(pa), 64'd1);
    chk("t1.jdo_after", 64'(jdo_a), 64'h1);
    pulse_ack();

    // 2. action command, IR=1; pulse after the 2nd edge from first sample
    do_uir(3'b001);
    sr = 38'h08_0000_1234;
    vs_udr = 1'b1;
    @(negedge clk); chk("t2.ta_E0", 64'(ta_a), 64'h0);
    @(negedge clk); chk("t2.ta_E1", 64'(ta_a), 64'h0);
    @(negedge clk); chk("t2.ta_E2", 64'(ta_a), 64'h2);
    chk("t2.tna_E2", 64'(tna_a), 64'h0);
    @(negedge clk); chk("t2.ta_E3", 64'(ta_a), 64'h0);
    vs_udr = 1'b0;
    wait_n(4);
    chk("t2.jdo", 64'(jdo_a), 64'h08_0000_1234);
    chk("t2.cmd_ir", 64'(cmd_ir_a), 64'd1);
    pulse_ack();

    // 3. no-action command, IR=3
    do_uir(3'b011);
    sr = 38'h00_DEAD_BEEF;
    vs_udr = 1'b1;
    wait_n(3);
    chk("t3.tna_E2", 64'(tna_a), 64'h8);
    chk("t3.ta_E2", 64'(ta_a), 64'h0);
    @(negedge clk); chk("t3.tna_E3", 64'(tna_a), 64'h0);
    vs_udr = 1'b0;
    wait_n(4);
    pulse_ack();

    // 4. handshake overrun on B
    send_cmd(38'hAA, pa, pb);
    chk("t4.A_pending", 64'(pend_b), 64'd1);
    send_cmd(38'hBB, pa, pb);
    chk("t4.B_pending", 64'(pend_b), 64'd1);
    chk("t4.B_jdo_keeps_A", 64'(jdo_b), 64'hAA);
    chk("t4.B_overrun", 64'(ovr_b), 64'd1);
    chk("t4.B_no_pulse", 64'(pb), 64'd0);
    pulse_ack();
    chk("t4.ack_pending", 64'(pend_b), 64'd0);
    send_cmd(38'hCC, pa, pb);
    chk("t4.C_pulse", 64'(pb), 64'd1);
    chk("t4.C_jdo", 64'(jdo_b), 64'hCC);
    // ack on the same edge as a new update-DR rise
    sr = 38'hDD;
    vs_udr = 1'b1;
    wait_n(2);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    @(negedge clk);
    vs_udr = 1'b0;
    wait_n(4);
    chk("t4.same_pending", 64'(pend_b), 64'd0);
    chk("t4.same_overrun", 64'(ovr_b), 64'd2);
    chk("t4.same_jdo", 64'(jdo_b), 64'hCC);
    send_cmd(38'hEE, pa, pb);
    chk("t4.D_pulse", 64'(pb), 64'd1);
    chk("t4.D_pending", 64'(pend_b), 64'd1);

    // 5. saturation of the 2-bit overrun counter
    pc = 0;
    for (int i = 0; i < 5; i++) begin
      send_cmd(38'h100 + 38'(i), pa, pb);
      pc += pb;
    end
    chk("t5.overrun_sat", 64'(ovr_b), 64'd3);
    chk("t5.no_pulse", 64'(pc), 64'd0);
    chk("t5.jdo_hold", 64'(jdo_b), 64'hEE);
    wait_n(10);
    chk("t5.overrun_stays", 64'(ovr_b), 64'd3);
    pulse_ack();

    // 6. scaled instance C: IR=6, three sync stages
    do_uir(3'd6);
    sr = 38'h08_0000_0006;
    vs_udr = 1'b1;
    @(negedge clk); chk("t6.ta_E0", 64'(ta_c), 64'h0);
    @(negedge clk); chk("t6.ta_E1", 64'(ta_c), 64'h0);
    @(negedge clk); chk("t6.ta_E2", 64'(ta_c), 64'h0);
    @(negedge clk); chk("t6.ta_E3", 64'(ta_c), 64'h40);
    chk("t6.cmd_ir", 64'(cmd_ir_c), 64'd6);
    @(negedge clk); chk("t6.ta_E4", 64'(ta_c), 64'h0);
    vs_udr = 1'b0;
    wait_n(4);
    // reset on the edge before the pulse aborts the command
    sr = 38'h08_0000_0007;
    vs_udr = 1'b1;
    wait_n(2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6.rst_jdo", 64'(jdo_c), 64'h0);
    chk("t6.rst_cmd_ir", 64'(cmd_ir_c), 64'h0);
    chk("t6.rst_ta", 64'(ta_c), 64'h0);
    chk("t6.rst_tna", 64'(tna_c), 64'h0);
    chk("t6.rst_pending", 64'(pend_c), 64'h0);
    chk("t6.rst_overrun", 64'(ovr_c), 64'h0);
    reset_n = 1'b1;
    pc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ((ta_c | tna_c) != 8'h0) pc++;
    end
    chk("t6.aborted_no_pulse", 64'(pc), 64'd0);
    vs_udr = 1'b0;
    wait_n(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_debug_cmd_sysclk_bridge.md
Name: jtag_debug_cmd_sysclk_bridge

Overview:
- Parametrised system-clock side of the CPU JTAG debug link, and the successor to the fixed 2-bit IR / 38-bit DR sysclk stage.
- Synchronises the virtual-JTAG update strobes (vs_uir, vs_udr) into clk and captures the shift register into jdo.
- Decodes the IR into one-hot take_action / take_no_action pulses, scaled by IR_WIDTH.
- Adds an optional consumer ack handshake and a saturating overrun counter for commands dropped while busy.

Parameters:
IR_WIDTH  2  width of ir_in; 2**IR_WIDTH command channels
DR_WIDTH  38  width of sr / jdo
ACT_BIT  35  sr bit selecting action (1) vs no-action (0)
SYNC_STAGES  2  synchroniser depth for vs_uir/vs_udr, legal 2..4
HANDSHAKE  0  1 = hold command pending until cmd_ack
OVR_WIDTH  8  width of overrun counter

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
ir_in  in  IR_WIDTH  virtual IR, tck domain, quasi-static
sr  in  DR_WIDTH  JTAG shift register, tck domain, stable after vs_udr
vs_uir  in  1  update-IR strobe, tck domain
vs_udr  in  1  update-DR strobe, tck domain
cmd_ack  in  1  consumer done (HANDSHAKE=1 only; ignored otherwise)
jdo  out  DR_WIDTH  captured DR contents
cmd_ir  out  IR_WIDTH  IR of the last accepted command
take_action  out  2**IR_WIDTH  one-hot 1-cycle pulse, sr[ACT_BIT]=1
take_no_action  out  2**IR_WIDTH  one-hot 1-cycle pulse, sr[ACT_BIT]=0
cmd_pending  out  1  command accepted, not yet acked
overrun_cnt  out  OVR_WIDTH  dropped-command count, saturating

Behaviour:
- Reset: all of the following clear to 0 — every output, the synchroniser flops, the edge-detect delay flops and the internal ir_latched. The state machine returns to IDLE and the arm flags clear.
- Reset is sampled on clk only. Reset asserted mid-command aborts it: no pulse and no pending state survive.
- Synchronisers: vs_uir and vs_udr each pass through SYNC_STAGES flops. A rise is sync high while its delay flop is low.
- Arm flags: a rise is honoured only after that sync output has been seen low at least once since reset. A strobe held high across reset release is therefore ignored.
- UIR rise: ir_latched <= ir_in, sampled directly because it is quasi-static. This happens in any state and does not change cmd_ir.
- UDR rise with simultaneous UIR rise: the new ir_in value is used for that command.
- States: IDLE, WAIT_ACK.
- IDLE + UDR rise (clock edge En):
  - jdo <= sr and cmd_ir <= ir_latched, visible after En.
  - Exactly one of take_action[ir_latched] / take_no_action[ir_latched] is high for the one cycle after En, selected by sr[ACT_BIT]. All other bits are 0.
  - If HANDSHAKE=1: go to WAIT_ACK and set cmd_pending=1 from the same edge. Otherwise stay in IDLE.
- Latency: first clk edge sampling vs_udr=1 is E0; the pulse is asserted after edge E(SYNC_STAGES). For SYNC_STAGES=2 that is 2 edges after E0.
- WAIT_ACK:
  - cmd_ack=1 -> IDLE and cmd_pending <= 0.
  - A UDR rise in WAIT_ACK is dropped. jdo and cmd_ir hold, no pulse is issued and overrun_cnt increments.
  - This applies even in the same cycle as cmd_ack: ack wins and the new command is still dropped and counted.
- cmd_ack in IDLE is ignored.
- overrun_cnt saturates at all-ones. It clears only on reset.
- HANDSHAKE=0: commands never drop. Back-to-back UDR rises each produce a pulse; the minimum spacing is 2 clk cycles, set by the edge detect.
- jdo holds its value between commands. It is never cleared except by reset.

Test Plan:
1. Reset behaviour:
   - With vs_udr held high through reset release, de-assert reset and hold 20 cycles -> no pulse, jdo=0, overrun_cnt=0.
   - Then take vs_udr low and high again -> one pulse.
2. Action command (defaults):
   - vs_uir with ir_in=2'b01.
   - Then vs_udr with sr=38'h08_0000_1234, so bit35=1.
   - Required: take_action=4'b0010 for exactly 1 cycle, 2 edges after vs_udr is first sampled; jdo=38'h08_0000_1234; cmd_ir=1; take_no_action stays 0.
3. No-action command:
   - ir_in=2'b11, sr bit35=0, sr=38'h00_DEAD_BEEF.
   - Required: take_no_action=4'b1000 for 1 cycle; take_action=0.
4. HANDSHAKE=1 overrun:
   - Issue cmd A, then cmd B (different sr) before cmd_ack.
   - Required: cmd_pending=1 throughout; jdo keeps A; overrun_cnt=1.
   - After cmd_ack: cmd_pending=0, and a new cmd C is accepted with a pulse.
   - Also drive cmd_ack in the same cycle as a UDR rise -> state returns to IDLE and overrun_cnt increments.
5. Counter saturation:
   - OVR_WIDTH=2, HANDSHAKE=1; issue 1 accepted command + 5 dropped.
   - Required: overrun_cnt=2'b11 and stays there.
6. Scaling:
   - IR_WIDTH=3, SYNC_STAGES=3, ir_in=3'd6.
   - Required: take_action=8'b0100_0000, asserted after the 3rd edge from first sample.
   - Also assert reset one cycle before the pulse would fire -> no pulse, and all outputs 0.
